// File: rtl/height_digit_renderer.sv
// Height readout: double-dabble binary-to-BCD conversion plus a 2-stage glyph ROM pixel pipeline.
// Optional build macro LEADING_ZERO_BLANK_EN draws leading zero cells (all but the last) as background.
module height_digit_renderer #(
    parameter int NUM_DIGITS  = 3,
    parameter int VALUE_W     = 10,
    parameter int ORIGIN_X    = 16,
    parameter int ORIGIN_Y    = 16,
    parameter int DIGIT_PITCH = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [VALUE_W-1:0] value_in,
    input  logic               value_load,
    output logic               busy,
    input  logic [9:0]         px_x,
    input  logic [9:0]         px_y,
    input  logic               px_valid,
    output logic [3:0]         glyph_digit,
    output logic [4:0]         glyph_col,
    output logic [4:0]         glyph_row,
    input  logic [5:0]         glyph_data,
    output logic [5:0]         pix_data,
    output logic               pix_valid
);

    // state   | meaning
    // IDLE    | waiting for value_load
    // CONVERT | VALUE_W add-3/shift steps
    // DONE    | clamp and copy digits to display, drop busy

    // BCD field is wide enough for the full binary range so clamping can see overflow digits.
    localparam int BCD_MIN = (VALUE_W * 301) / 1000 + 1;
    localparam int BCD_N   = (BCD_MIN > NUM_DIGITS) ? BCD_MIN : NUM_DIGITS;
    localparam int DD_W    = BCD_N * 4 + VALUE_W;
    localparam int CNT_W   = $clog2(VALUE_W + 1);

    localparam logic [9:0] OX   = 10'(ORIGIN_X);
    localparam logic [9:0] OY   = 10'(ORIGIN_Y);
    localparam logic [9:0] SPAN = 10'(NUM_DIGITS * DIGIT_PITCH);

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t            state;
    logic [DD_W-1:0]   dd_q;
    logic [DD_W-1:0]   dd_step;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        disp      [NUM_DIGITS];
    logic [3:0]        disp_next [NUM_DIGITS];
    logic              overflow;

    always_comb begin
        dd_step = dd_q;
        for (int d = 0; d < BCD_N; d++) begin
            if (dd_step[VALUE_W+4*d +: 4] >= 4'd5)
                dd_step[VALUE_W+4*d +: 4] = dd_step[VALUE_W+4*d +: 4] + 4'd3;
        end
        dd_step = dd_step << 1;
    end

    // Cell 0 is the most significant digit; any nonzero digit beyond the cells clamps to all nines.
    always_comb begin
        overflow = 1'b0;
        for (int d = NUM_DIGITS; d < BCD_N; d++)
            overflow = overflow | (dd_q[VALUE_W+4*d +: 4] != 4'd0);
        for (int k = 0; k < NUM_DIGITS; k++)
            disp_next[k] = overflow ? 4'd9 : dd_q[VALUE_W+4*(NUM_DIGITS-1-k) +: 4];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            dd_q  <= '0;
            cnt   <= '0;
            for (int k = 0; k < NUM_DIGITS; k++)
                disp[k] <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (value_load) begin
                        dd_q  <= {{(BCD_N*4){1'b0}}, value_in};
                        cnt   <= CNT_W'(VALUE_W - 1);
                        busy  <= 1'b1;
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    dd_q <= dd_step;
                    if (cnt == '0)
                        state <= DONE;
                    else
                        cnt <= cnt - 1'b1;
                end
                DONE: begin
                    for (int k = 0; k < NUM_DIGITS; k++)
                        disp[k] <= disp_next[k];
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank;
    logic [NUM_DIGITS-1:0] blank_next;
    logic                  seen_nz;

    always_comb begin
        blank_next = '0;
        seen_nz    = 1'b0;
        for (int k = 0; k < NUM_DIGITS - 1; k++) begin
            seen_nz       = seen_nz | (disp_next[k] != 4'd0);
            blank_next[k] = !seen_nz;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blank                 <= '1;
            blank[NUM_DIGITS-1]   <= 1'b0;
        end else if (state == DONE) begin
            blank <= blank_next;
        end
    end
`endif

    logic [9:0] dx;
    logic [9:0] dy;
    logic [9:0] lcol;
    logic [3:0] sel_digit;
    logic       sel_blank;
    logic       in_box;
    logic       hit;
    logic       s1_valid;
    logic       s1_in;

    // Cell select by range comparison: the last cell base not above dx wins.
    always_comb begin
        dx        = px_x - OX;
        dy        = px_y - OY;
        in_box    = (px_x >= OX) && (dx < SPAN) && (px_y >= OY) && (dy < 10'd16);
        sel_digit = 4'd0;
        sel_blank = 1'b0;
        lcol      = dx;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (dx >= 10'(k * DIGIT_PITCH)) begin
                sel_digit = disp[k];
                lcol      = dx - 10'(k * DIGIT_PITCH);
`ifdef LEADING_ZERO_BLANK_EN
                sel_blank = blank[k];
`endif
            end
        end
        hit = in_box && (lcol < 10'd8) && !sel_blank;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_in       <= 1'b0;
            glyph_digit <= 4'd0;
            glyph_col   <= 5'd0;
            glyph_row   <= 5'd0;
            pix_valid   <= 1'b0;
            pix_data    <= 6'b111111;
        end else begin
            s1_valid <= px_valid;
            if (px_valid) begin
                s1_in       <= hit;
                glyph_digit <= hit ? sel_digit : 4'd0;
                glyph_col   <= hit ? lcol[4:0] : 5'd0;
                glyph_row   <= hit ? dy[4:0]   : 5'd0;
            end
            pix_valid <= s1_valid;
            pix_data  <= (s1_valid && s1_in) ? glyph_data : 6'b111111;
        end
    end

endmodule
